sevenseg_count_display: RTL



---
 rtl/sevenseg_pkg.sv | 18 +
 rtl/sevenseg_count_display_bin2bcd.sv | 60 ++++++
 rtl/sevenseg_count_display.sv | 53 +++++
 3 files changed

// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared constants, segment encoding and converter state encoding
package sevenseg_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  // {g,f,e,d,c,b,a} active-low; codes 10-15 are unreachable and shown blank
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
    SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK
  };
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    return SEG_LUT[d];
  endfunction
  function automatic int digits_for(input int w);
    return w <= 3 ? 1 : w <= 6 ? 2 : w <= 9 ? 3 : 4;
  endfunction
endpackage

// File: rtl/sevenseg_count_display_bin2bcd.sv
// bin2bcd_seq: sequential double-dabble, one bit per clock, atomic BCD result update
module bin2bcd_seq
  import sevenseg_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_start,
  input  logic [W-1:0] i_value,
  output logic         o_busy,
  output logic [15:0]  o_bcd,
  output logic         o_done
);
  localparam int ND = digits_for(W);
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  state_t r_state, w_next;
  logic [W-1:0]  r_sr;
  logic [15:0]   r_scr, w_adj;
  logic [CW-1:0] r_cnt;
  // only nibbles that the input width can actually reach get the add-3 step
  always_comb begin
    w_adj = r_scr;
    for (int k = 0; k < ND; k++)
      if (r_scr[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_scr[4*k +: 4] + 4'd3;
  end
  always_comb begin
    w_next = (r_state == IDLE && i_start) ? SHIFT :
             (r_state == SHIFT && r_cnt == LAST) ? DONE :
             (r_state == DONE) ? IDLE : r_state;
    o_done = r_state == DONE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_scr   <= '0;
      r_cnt   <= '0;
      o_busy  <= 1'b0;
      o_bcd   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && i_start) begin
        r_sr   <= i_value;
        r_scr  <= '0;
        r_cnt  <= '0;
        o_busy <= 1'b1;
      end
      if (r_state == SHIFT) begin
        r_scr <= {w_adj[14:0], r_sr[W-1]};
        r_sr  <= r_sr << 1;
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == DONE) begin
        o_bcd  <= r_scr;
        o_busy <= 1'b0;
      end
    end
endmodule

// File: rtl/sevenseg_count_display.sv
// sevenseg_count_display: binary count -> BCD -> multiplexed 4-digit common-anode display.
// Optional LEAD_ZERO_BLANK_EN blanks digits above the most significant nonzero digit.
module sevenseg_count_display
  import sevenseg_pkg::*;
#(
  parameter int COUNT_SIZE = 8,
  parameter int SCAN_DIV   = 1250
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [COUNT_SIZE-1:0] count,
  output logic [3:0]            an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  busy
);
  localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  logic [COUNT_SIZE-1:0] r_sample, r_last;
  logic [DW-1:0]         r_div;
  logic [1:0]            r_idx;
  logic [15:0]           w_bcd;
  logic [3:0]            w_digit;
  logic                  w_done, w_start, w_tc, w_blank;
  assign w_start = !(busy | w_done) && r_sample != r_last;
  assign w_tc    = r_div == DW'(SCAN_DIV - 1);
  assign w_digit = w_bcd[{r_idx, 2'b00} +: 4];
  assign dp      = 1'b1;
`ifdef LEAD_ZERO_BLANK_EN
  assign w_blank = r_idx != 2'd0 && (w_bcd >> {r_idx, 2'b00}) == 16'd0;
`else
  assign w_blank = 1'b0;
`endif
  bin2bcd_seq #(.W(COUNT_SIZE)) u_conv (
    .clk(clk), .reset(reset), .i_start(w_start), .i_value(r_sample),
    .o_busy(busy), .o_bcd(w_bcd), .o_done(w_done)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_sample <= '0;
      r_last   <= '0;
      r_div    <= '0;
      r_idx    <= '0;
      an       <= 4'b1111;
      seg      <= SEG_BLANK;
    end else begin
      r_sample <= count;
      if (w_start) r_last <= r_sample;
      r_div <= w_tc ? '0 : r_div + 1'b1;
      if (w_tc) r_idx <= r_idx + 1'b1;
      an  <= ~(4'b0001 << r_idx);
      seg <= w_blank ? SEG_BLANK : seg_encode(w_digit);
    end
endmodule
